cpu_register_bank: RTL and testbench

CPU_REGISTER_BANK -- requirements
Module: cpu_register_bank

---
 rtl/cpu_register_bank.sv | 159 +++++++++++++++
 tb/tb_cpu_register_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_register_bank.sv
// -----------------------------------------------------------------------------
// cpu_register_bank
//
// Multi-read, single-write CPU register file. After reset it runs a CLEAR
// sequence that writes one register per cycle (one chosen register receives
// INIT_VALUE, all others zero). It then enters READY and serves reads and
// writes. Register 0 always reads as zero.
//
// Parameters
//   XLEN       register width in bits
//   NREGS      register count, power of two, 2..64
//   NREAD      number of read ports, 1..4
//   INIT_INDEX register that receives INIT_VALUE during CLEAR
//   INIT_VALUE post-clear value of INIT_INDEX, truncated to XLEN
//
// Ports
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset; restarts CLEAR from index 0
//   busy      high while CLEAR runs (registered)
//   rd_en     per-port read request
//   rd_addr   packed read addresses; port p uses [p*AW +: AW]
//   rd_data   packed registered read data; port p uses [p*XLEN +: XLEN]
//   rd_valid  per-port strobe, high the cycle after an accepted read
//   we        write request
//   waddr     write address
//   wdata     write data
//   wr_ack    one-cycle pulse the cycle after an accepted write
// -----------------------------------------------------------------------------
module cpu_register_bank #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned INIT_INDEX = 2,
  parameter logic [31:0] INIT_VALUE = 32'd1,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  busy,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_valid,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  output logic                  wr_ack
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [AW-1:0]   LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW-1:0]   INIT_ADDR = AW'(INIT_INDEX);
  // Register 0 is hard-wired to zero, so an init value aimed at it is dropped.
  localparam logic [XLEN-1:0] INIT_WORD = (INIT_INDEX == 0) ? '0 : XLEN'(INIT_VALUE);

  state_t        state;
  logic [AW-1:0] clr_idx;

  // ---------------------------------------------------------------------------
  // Control: CLEAR walks every index once, then READY accepts traffic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
      wr_ack  <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == LAST_IDX) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          // Writes to register 0 are dropped but still acknowledged.
          wr_ack <= we;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write port: the CLEAR sequencer owns it until READY.
  // ---------------------------------------------------------------------------
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx;
      mem_wdata = (clr_idx == INIT_ADDR) ? INIT_WORD : '0;
    end else if (we && (waddr != '0)) begin
      mem_we = 1'b1;
    end
  end

  logic [XLEN-1:0] mem [NREGS];

  // NOTE: the array has no reset so it maps onto RAM/register-file cells;
  // its contents become defined only through the CLEAR sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: registered, latency 1, write-first bypass per port.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] data_q;
    logic            valid_q;
    logic            accept;

    assign addr   = rd_addr[p*AW +: AW];
    assign accept = (state == READY) && rd_en[p];

    always_comb begin
      value = mem[addr];
      if (addr == '0) begin
        value = '0;
      end else if (we && (waddr == addr)) begin
        value = wdata;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= accept;
        if (accept) begin
          data_q <= value;
        end
      end
    end

    assign rd_data[p*XLEN +: XLEN] = data_q;
    assign rd_valid[p]             = valid_q;
  end

endmodule

// File: tb/tb_cpu_register_bank.sv
// -----------------------------------------------------------------------------
// tb_cpu_register_bank
//
// Directed bench for cpu_register_bank. Two instances: the default
// configuration (32 x 32-bit, 2 read ports, reg 2 = 1 after clear) and a
// small one (16 x 16-bit, 3 read ports, init aimed at reg 0).
// Read expectations are queued when a read is issued and popped once the
// registered data appears one cycle later.
// -----------------------------------------------------------------------------
module tb_cpu_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        resetn;
  logic        busy;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wr_ack;

  // Small instance
  logic        s_resetn;
  logic        s_busy;
  logic [2:0]  s_rd_en;
  logic [11:0] s_rd_addr;
  logic [47:0] s_rd_data;
  logic [2:0]  s_rd_valid;
  logic        s_we;
  logic [3:0]  s_waddr;
  logic [15:0] s_wdata;
  logic        s_wr_ack;

  cpu_register_bank dut (
    .clk      (clk),
    .resetn   (resetn),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wr_ack   (wr_ack)
  );

  cpu_register_bank #(
    .XLEN       (16),
    .NREGS      (16),
    .NREAD      (3),
    .INIT_INDEX (0)
  ) dut_small (
    .clk      (clk),
    .resetn   (s_resetn),
    .busy     (s_busy),
    .rd_en    (s_rd_en),
    .rd_addr  (s_rd_addr),
    .rd_data  (s_rd_data),
    .rd_valid (s_rd_valid),
    .we       (s_we),
    .waddr    (s_waddr),
    .wdata    (s_wdata),
    .wr_ack   (s_wr_ack)
  );

  typedef struct {
    string       tag;
    int          dut_id;
    int          port;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Contents of the default instance right after a completed clear.
  task automatic reset_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[2] = 32'd1;
  endtask

  task automatic drain();
    rd_exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut_id == 0)
        check(e.tag, 64'({rd_valid[e.port], rd_data[e.port*32 +: 32]}), 64'({1'b1, e.data}));
      else
        check(e.tag, 64'({s_rd_valid[e.port], s_rd_data[e.port*16 +: 16]}), 64'({1'b1, e.data[15:0]}));
    end
  endtask

  // One READY cycle on the default instance: drive, queue expectations,
  // clock, then compare wr_ack and read results.
  task automatic step(input logic we_i, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
    logic [4:0]  a;
    logic [31:0] d;
    we      = we_i;
    waddr   = wa;
    wdata   = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    for (int p = 0; p < 2; p++) begin
      if (re[p]) begin
        a = (p == 0) ? a0 : a1;
        if (a == 5'd0)             d = 32'd0;
        else if (we_i && wa == a)  d = wd;
        else                       d = model[a];
        sb.push_back('{$sformatf("rd%0d_a%0d", p, a), 0, p, d});
      end
    end
    if (we_i && wa != 5'd0) model[wa] = wd;
    @(posedge clk); #1;
    check("wr_ack", 64'(wr_ack), 64'(we_i));
    drain();
    for (int p = 0; p < 2; p++)
      if (!re[p]) check($sformatf("idle_valid%0d", p), 64'(rd_valid[p]), 64'd0);
    we    = 1'b0;
    rd_en = 2'b00;
  endtask

  // Called right after reset release on a falling edge; counts the cycles
  // busy stays high, bounded so a stuck clear still reaches the summary.
  task automatic wait_clear(input int exp_cycles);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (busy && cnt < 200);
    check("busy_cycles", 64'(cnt), 64'(exp_cycles));
  endtask

  initial begin
    int cnt;
    resetn    = 1'b0;
    rd_en     = '0;
    rd_addr   = '0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    s_resetn  = 1'b0;
    s_rd_en   = '0;
    s_rd_addr = '0;
    s_we      = 1'b0;
    s_waddr   = '0;
    s_wdata   = '0;

    // ---- Reset state and first clear -----------------------------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     64'(busy),     64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_ack",   64'(wr_ack),   64'd0);
    check("rst_rd_data",  rd_data,       64'd0);
    resetn = 1'b1;
    wait_clear(32);
    reset_model();

    // Post-clear contents: all zero except reg 2 = 1.
    for (int i = 0; i < 32; i += 2) step(1'b0, 5'd0, 32'd0, 2'b11, 5'(i), 5'(i + 1));
    step(1'b0, 5'd0, 32'd0, 2'b10, 5'd0, 5'd2);
    check("init_reg2", 64'(rd_data[63:32]), 64'd1);

    // ---- Write then read ------------------------------------------------
    step(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 2'b01, 5'd5, 5'd0);
    check("wr5_rd5", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // ---- Same-cycle write/read bypass on both ports ----------------------
    step(1'b1, 5'd7, 32'h12345678, 2'b11, 5'd7, 5'd7);
    check("bypass_p0", 64'(rd_data[31:0]),  64'h12345678);
    check("bypass_p1", 64'(rd_data[63:32]), 64'h12345678);
    step(1'b0, 5'd0, 32'd0, 2'b11, 5'd7, 5'd5);

    // ---- Writes to register 0 are acknowledged but dropped --------------
    step(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd0);
    check("reg0_zero", rd_data, 64'd0);

    // ---- Idle port holds its data -----------------------------------------
    step(1'b0, 5'd0, 32'd0, 2'b10, 5'd0, 5'd5);
    step(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    check("hold_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);

    // ---- Reset during READY, then again during the second clear ----------
    step(1'b1, 5'd9, 32'hA5A5A5A5, 2'b00, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 2'b01, 5'd9, 5'd0);
    resetn = 1'b0;
    #1;
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_rd_data",  rd_data,       64'd0);
    check("async_busy",     64'(busy),     64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_clear_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    wait_clear(32);
    reset_model();
    step(1'b0, 5'd0, 32'd0, 2'b11, 5'd9, 5'd2);
    check("reg9_cleared", 64'(rd_data[31:0]), 64'd0);
    step(1'b0, 5'd0, 32'd0, 2'b11, 5'd5, 5'd7);

    // ---- Small instance: traffic during clear is ignored ----------------
    s_we      = 1'b1;
    s_waddr   = 4'd3;
    s_wdata   = 16'hBEEF;
    s_rd_en   = 3'b111;
    s_rd_addr = {4'd3, 4'd0, 4'd3};
    @(negedge clk);
    s_resetn = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1 || cnt == 8 || cnt == 16) begin
        check($sformatf("s_clr_ack_c%0d", cnt),   64'(s_wr_ack),   64'd0);
        check($sformatf("s_clr_valid_c%0d", cnt), 64'(s_rd_valid), 64'd0);
        check($sformatf("s_clr_data_c%0d", cnt),  64'(s_rd_data),  64'd0);
      end
    end while (s_busy && cnt < 200);
    check("s_busy_cycles", 64'(cnt), 64'd16);
    s_we    = 1'b0;
    s_rd_en = 3'b000;

    // Every register reads zero, including reg 0 (its init value is dropped).
    for (int i = 0; i < 16; i += 3) begin
      s_rd_en   = 3'b111;
      s_rd_addr = {4'((i + 2) % 16), 4'((i + 1) % 16), 4'(i)};
      for (int p = 0; p < 3; p++)
        sb.push_back('{$sformatf("s_rd%0d_a%0d", p, (i + p) % 16), 1, p, 32'd0});
      @(posedge clk); #1;
      check("s_wr_ack", 64'(s_wr_ack), 64'd0);
      drain();
    end
    s_rd_en = 3'b000;
    @(posedge clk); #1;
    check("s_idle_valid", 64'(s_rd_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
